// File: rtl/overture_loader_if.sv
// rtl/overture_loader_if.sv - stream-in and program-memory write bus for overture_loader
//
// Signals:
//   in_valid, in_data[7:0]  byte stream offered to the loader
//   in_ready                loader can take a byte this cycle
//   rom_we, rom_addr[7:0],
//   rom_wdata[7:0]          program-memory write port driven by the loader
// Modports:
//   slave   the loader's view (consumes the stream, drives the write port)
//   master  the environment's view (drives the stream, observes the write port)
interface overture_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       rom_we;
    logic [7:0] rom_addr;
    logic [7:0] rom_wdata;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output rom_we,
        output rom_addr,
        output rom_wdata
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  rom_we,
        input  rom_addr,
        input  rom_wdata
    );
endinterface

// File: rtl/overture_loader.sv
// rtl/overture_loader.sv - framed program loader and boot controller for overture_cpu
//
// Accepts a frame {L, N payload bytes, C} (N = L, or 256 when L = 0), writes the
// payload to program memory from address 0, checks that the 8-bit sum of payload
// plus C is zero, then holds cpu_reset for BOOT_CYCLES cycles and raises cpu_run.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   abort             synchronous return to IDLE from any state
//   bus (slave)       in_valid/in_data/in_ready stream, rom_we/rom_addr/rom_wdata
//   cpu_reset         CPU reset, high only in BOOT
//   cpu_run           CPU run, high only in RUN
//   busy              high in LOAD, CHECK and BOOT
//   done              high in RUN
//   error             high in ERROR (memory contents invalid)
//   loaded_len[8:0]   payload length of the last accepted header
module overture_loader #(
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                abort,
    overture_loader_if.slave    bus,
    output logic                cpu_reset,
    output logic                cpu_run,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [8:0]          loaded_len
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_BOOT,
        S_RUN,
        S_ERROR
    } state_t;

    state_t     state, state_n;

    logic [8:0] remain, remain_n;
    logic [7:0] addr_cnt, addr_n;
    logic [7:0] sum, sum_n;
    logic [3:0] boot_cnt, boot_n;
    logic [8:0] len_n;

    logic       in_ready_q, ready_n;
    logic       rom_we_q, we_n;
    logic [7:0] rom_addr_q, waddr_n;
    logic [7:0] rom_wdata_q, wdata_n;
    logic       cpu_reset_n, cpu_run_n, busy_n, done_n, error_n;

    logic       accept;
    logic [7:0] sum_check;

    // The handshake is qualified by the registered in_ready, so a byte is
    // only taken in a state that advertised readiness; abort outranks it.
    assign accept    = bus.in_valid && in_ready_q && !abort;
    assign sum_check = sum + bus.in_data;

    always_comb begin
        state_n = state;
        remain_n = remain;
        addr_n = addr_cnt;
        sum_n = sum;
        boot_n = boot_cnt;
        len_n = loaded_len;
        we_n = 1'b0;
        waddr_n = rom_addr_q;
        wdata_n = rom_wdata_q;

        if (abort) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        len_n = (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
                        remain_n = len_n;
                        addr_n = 8'd0;
                        sum_n = 8'd0;
                        state_n = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        we_n = 1'b1;
                        waddr_n = addr_cnt;
                        wdata_n = bus.in_data;
                        sum_n = sum_check;
                        remain_n = remain - 9'd1;
                        // Hold the address on the last byte so a 256-byte
                        // frame finishes at 0xFF instead of wrapping.
                        if (remain == 9'd1) begin
                            state_n = S_CHECK;
                        end else begin
                            addr_n = addr_cnt + 8'd1;
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        boot_n = 4'(BOOT_CYCLES - 1);
                        state_n = (sum_check == 8'd0) ? S_BOOT : S_ERROR;
                    end
                end
                S_BOOT: begin
                    if (boot_cnt == 4'd0) begin
                        state_n = S_RUN;
                    end else begin
                        boot_n = boot_cnt - 4'd1;
                    end
                end
                S_RUN:   state_n = S_RUN;
                S_ERROR: state_n = S_ERROR;
                default: state_n = S_IDLE;
            endcase
        end

        // Status outputs are registered from the next state so they line up
        // with the state register.
        ready_n = (state_n == S_IDLE) || (state_n == S_LOAD) || (state_n == S_CHECK);
        cpu_reset_n = (state_n == S_BOOT);
        cpu_run_n = (state_n == S_RUN);
        busy_n = (state_n == S_LOAD) || (state_n == S_CHECK) || (state_n == S_BOOT);
        done_n = (state_n == S_RUN);
        error_n = (state_n == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            remain <= 9'd0;
            addr_cnt <= 8'd0;
            sum <= 8'd0;
            boot_cnt <= 4'd0;
            loaded_len <= 9'd0;
            in_ready_q <= 1'b0;
            rom_we_q <= 1'b0;
            rom_addr_q <= 8'd0;
            rom_wdata_q <= 8'd0;
            cpu_reset <= 1'b0;
            cpu_run <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_n;
            remain <= remain_n;
            addr_cnt <= addr_n;
            sum <= sum_n;
            boot_cnt <= boot_n;
            loaded_len <= len_n;
            in_ready_q <= ready_n;
            rom_we_q <= we_n;
            rom_addr_q <= waddr_n;
            rom_wdata_q <= wdata_n;
            cpu_reset <= cpu_reset_n;
            cpu_run <= cpu_run_n;
            busy <= busy_n;
            done <= done_n;
            error <= error_n;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.rom_we    = rom_we_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.rom_wdata = rom_wdata_q;

endmodule

// File: doc/overture_loader.md
# overture_loader

Program loader and boot controller for `overture_cpu`. It accepts a framed byte stream over a valid/ready handshake and writes the payload into the CPU's 256-byte program memory starting at address 0. It verifies a modular checksum, then pulses the CPU reset and holds `run` high. It is the writer side of the program ROM that the CPU fetches from.

## Interface
- `BOOT_CYCLES`, default 1: number of cycles `cpu_reset` is held high before `cpu_run` rises. Legal range 1 to 15.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `abort`  in  1  synchronous return to IDLE from any state.
- `in_valid`  in  1  stream byte valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte; a byte transfers when `in_valid` and `in_ready` are both high at a clock edge.
- `rom_we`  out  1  program-memory write strobe, one cycle per payload byte.
- `rom_addr`  out  8  write address.
- `rom_wdata`  out  8  write data.
- `cpu_reset`  out  1  drives the CPU `reset` input.
- `cpu_run`  out  1  drives the CPU `run` input.
- `busy`  out  1  high in LOAD, CHECK and BOOT.
- `done`  out  1  high in RUN.
- `error`  out  1  high in ERROR.
- `loaded_len`  out  9  payload length of the last accepted header (1 to 256).

## Operation
- Frame format: a length byte L, then N payload bytes, then a checksum byte C.
  - N = L, except L = 0 means N = 256.
  - The frame is valid when the 8-bit sum of all payload bytes plus C equals 0x00, modulo 256.
- States and transitions:
  - IDLE: `in_ready`=1. Accepting L latches N into `loaded_len` and the remaining-count, clears the address and sum, then goes to LOAD.
  - LOAD: `in_ready`=1. Each accepted byte is written to the current address, the address increments and the sum accumulates. Accepting byte N goes to CHECK.
  - CHECK: `in_ready`=1. Accepting C goes to BOOT if (sum + C) mod 256 = 0, otherwise to ERROR.
  - BOOT: `in_ready`=0, `cpu_reset`=1 for exactly `BOOT_CYCLES` cycles, then go to RUN.
  - RUN: `in_ready`=0, `cpu_run`=1, `done`=1. Stays here until `abort` or `reset`.
  - ERROR: `in_ready`=0, `error`=1, `cpu_run`=0. Stays here until `abort` or `reset`.
- `abort` in any state goes to IDLE and clears `cpu_run`, `cpu_reset` and `rom_we` on the next cycle. Memory contents already written are left unchanged.
- Width rules:
  - The address counter is 8 bits. For N = 256 it ends at 0xFF and never wraps mid-frame.
  - The remaining-count is 9 bits.
  - The checksum accumulator is 8 bits and wraps.
- `cpu_reset` is low in every state except BOOT. The CPU is never left in reset after BOOT.
- Payload bytes are written even if the frame later fails its checksum. `error` flags that the memory contents are invalid.

## Timing
- Reset values:
  - `in_ready`=0 during reset, then 1 from the first cycle after reset deasserts (IDLE).
  - `rom_we`=0, `rom_addr`=0, `rom_wdata`=0.
  - `cpu_reset`=0, `cpu_run`=0, `busy`=0, `done`=0, `error`=0, `loaded_len`=0.
- All outputs are registered.
- Write latency: a payload byte accepted at edge k appears on `rom_we`/`rom_addr`/`rom_wdata` for the single cycle between edge k and edge k+1. Memory captures it at edge k+1.
- Throughput is one byte per cycle with no bubbles. `in_ready` does not drop between L, the payload bytes, and C.
- Boot sequence: C is accepted at edge k. `cpu_reset`=1 for cycles k..k+BOOT_CYCLES-1. `cpu_run`=1 from edge k+BOOT_CYCLES onward.
- The CPU sees `reset` high on at least one rising edge after the last memory write has completed.
- Priority: `reset` > `abort` > handshake. A byte presented in the same cycle as `abort` is not accepted.
- `in_valid` low stalls any state with no side effects. The sum, count and address hold their values.

## Test plan
- Valid frame: send 0x03, 0x05, 0x81, 0xC4, 0xB6 back-to-back.
  - Expect writes (0x00, 0x05), (0x01, 0x81), (0x02, 0xC4) on consecutive cycles.
  - Expect `cpu_reset` high for 1 cycle, then `cpu_run`=1, `done`=1, `loaded_len`=3.
- Bad checksum: send the same frame with C = 0xB7.
  - Expect 3 writes, then `error`=1, `cpu_run`=0, `cpu_reset` never high, `in_ready`=0.
  - Then `abort` for 1 cycle: expect IDLE and `in_ready`=1.
- Length 0: send 0x00, then 256 payload bytes of 0x01, then C = 0x00.
  - Expect last write at address 0xFF, `loaded_len`=256, then RUN.
- Stalls: valid frame with `in_valid` toggled 1/0 every cycle.
  - Expect the same writes and checksum result as the back-to-back case, one write per accepted byte.
- Mid-load abort and reset: `abort` after the 2nd payload byte.
  - Expect IDLE next cycle, no further writes, and a new frame loads correctly.
  - Repeat with `reset`: expect all outputs at reset values.
- `BOOT_CYCLES`=4: valid frame.
  - Expect `cpu_reset` high for exactly 4 cycles and `cpu_run` rising on the following edge.
